decoder_seq: RTL and testbench

Sequenced 3-to-8 decoder: the receive-side counterpart of the team's 8-to-3 priority encoder. Accepts 3-bit codes over a valid/ready handshake into a small FIFO. Replays each code as a registered one-hot strobe on an 8-bit bus, held for a fixed number of cycles and followed by one all-zero guard cycle (break-before-make). Sits between a code source (encoder output or host register) and one-hot select lines (mux selects, LED/row drivers).

---
 rtl/decoder_pkg.sv | 24 ++
 rtl/decoder_fifo.sv | 54 +++++
 rtl/decoder_seq.sv | 111 +++++++++++
 tb/tb_decoder_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared definitions for the sequenced 3-to-8 decoder.
//   state_t  - FSM encoding (IDLE / DRIVE / GAP)
//   CODE_W   - width of an incoming code
//   ONEHOT_W - width of the decoded one-hot bus
//   onehot() - code to one-hot word
package decoder_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] word;
    word       = '0;
    word[code] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/decoder_fifo.sv
// decoder_fifo: synchronous FIFO with extra-bit pointers.
//   clk, rst     - clock, synchronous active-high reset (pointers only)
//   push, din    - write request / data (ignored when full)
//   pop, dout    - read request (ignored when empty) / head entry
//   full, empty  - occupancy flags, derived from the pointers
//   level        - current occupancy, 0..DEPTH
module decoder_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // The extra pointer bit makes the difference span 0..DEPTH without aliasing.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/decoder_seq.sv
// decoder_seq: queued 3-to-8 decoder with timed one-hot strobes.
//   clk, rst               - clock, synchronous active-high reset
//   code_in, code_valid    - code source; accepted when code_ready is high
//   code_ready             - FIFO not full
//   en                     - allows the next queued code to start
//   y, y_valid             - registered one-hot word, valid while in DRIVE
//   busy                   - FSM active or codes still queued
//   level                  - FIFO occupancy
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | y = 0, waiting for en and a queued code
//   DRIVE | y = one-hot of popped code, held for HOLD cycles
//   GAP   | y = 0 for one cycle (break-before-make)
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CODE_W-1:0]         code_in,
  input  logic                      code_valid,
  output logic                      code_ready,
  input  logic                      en,
  output logic [ONEHOT_W-1:0]       y,
  output logic                      y_valid,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level
);

  localparam logic [7:0] CNT_LOAD = 8'(HOLD - 1);

  state_t              state_q;
  state_t              state_nxt;
  logic [7:0]          cnt_q;
  logic [ONEHOT_W-1:0] y_q;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CODE_W-1:0]   head;

  assign code_ready = !full;

  decoder_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (code_valid),
    .din   (code_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // State register, hold counter and output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_nxt;
      if (pop) begin
        cnt_q <= CNT_LOAD;
        y_q   <= onehot(head);
      end else if (state_q == ST_DRIVE) begin
        if (cnt_q == 8'd0) y_q   <= '0;
        else               cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // Next state; en is only consulted when a new word could start.
  always_comb begin
    state_nxt = state_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !empty) begin
          state_nxt = ST_DRIVE;
          pop       = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 8'd0) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (en && !empty) begin
          state_nxt = ST_DRIVE;
          pop       = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    y       = y_q;
    y_valid = (state_q == ST_DRIVE);
    busy    = (state_q != ST_IDLE) || !empty;
  end

endmodule

// File: tb/tb_decoder_seq.sv
module tb_decoder_seq;

  logic       clk;
  logic       rst;
  logic [2:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic       en;
  logic [7:0] y;
  logic       y_valid;
  logic       busy;
  logic [2:0] level;

  logic [2:0] code_in1;
  logic       code_valid1;
  logic       code_ready1;
  logic       en1;
  logic [7:0] y1;
  logic       y_valid1;
  logic       busy1;
  logic [2:0] level1;

  int checks = 0;
  int errors = 0;

  decoder_seq #(.HOLD(4), .DEPTH(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .en         (en),
    .y          (y),
    .y_valid    (y_valid),
    .busy       (busy),
    .level      (level)
  );

  decoder_seq #(.HOLD(1), .DEPTH(4)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in1),
    .code_valid (code_valid1),
    .code_ready (code_ready1),
    .en         (en1),
    .y          (y1),
    .y_valid    (y_valid1),
    .busy       (busy1),
    .level      (level1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_code(input logic [2:0] c);
    code_in    = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (y !== 8'h00 || y_valid !== 1'b0 || busy !== 1'b0 || level !== 3'd0 || code_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: y=%h y_valid=%b busy=%b level=%0d code_ready=%b, required 00 0 0 0 1",
               y, y_valid, busy, level, code_ready);
    end
    checks++;
    if (y1 !== 8'h00 || busy1 !== 1'b0 || code_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold1: y=%h busy=%b code_ready=%b, required 00 0 1", y1, busy1, code_ready1);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    en = 1'b1;
    push_code(3'd5);
    checks++;
    if (level !== 3'd1 || y !== 8'h00) begin
      errors++;
      $display("FAIL single_accept: level=%0d y=%h, required 1 00", level, y);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (y !== 8'h20 || y_valid !== 1'b1) begin
        errors++;
        $display("FAIL single_drive k=%0d: y=%h y_valid=%b, required 20 1", k, y, y_valid);
      end
    end
    tick();
    checks++;
    if (y !== 8'h00 || y_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap: y=%h y_valid=%b busy=%b, required 00 0 1", y, y_valid, busy);
    end
    tick();
    checks++;
    if (y !== 8'h00 || busy !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL single_idle: y=%h busy=%b level=%0d, required 00 0 0", y, busy, level);
    end
  endtask

  task automatic test_burst();
    logic [7:0] col [40];
    logic       colv [40];
    int         idx = 0;
    int         ncol = 0;
    logic [2:0] max_lvl = 3'd0;
    logic       hs;
    logic [7:0] exp_y;
    en         = 1'b1;
    code_in    = 3'd0;
    code_valid = 1'b1;
    for (int cyc = 0; cyc < 300 && ncol < 40; cyc++) begin
      hs = code_valid && code_ready;
      tick();
      if (hs) idx++;
      code_valid = (idx < 8);
      code_in    = 3'(idx);
      checks++;
      if (code_ready !== (level != 3'd4)) begin
        errors++;
        $display("FAIL burst_ready cyc=%0d: code_ready=%b level=%0d, required ready=!(level==4)",
                 cyc, code_ready, level);
      end
      if (level > max_lvl) max_lvl = level;
      if (ncol > 0 || y != 8'h00) begin
        col[ncol]  = y;
        colv[ncol] = y_valid;
        ncol++;
      end
    end
    code_valid = 1'b0;
    checks++;
    if (ncol !== 40 || idx !== 8) begin
      errors++;
      $display("FAIL burst_count: samples=%0d pushes=%0d, required 40 8", ncol, idx);
    end
    checks++;
    if (max_lvl !== 3'd4) begin
      errors++;
      $display("FAIL burst_full: max level=%0d, required 4", max_lvl);
    end
    for (int j = 0; j < ncol; j++) begin
      exp_y = ((j % 5) < 4) ? (8'h01 << (j / 5)) : 8'h00;
      checks++;
      if (col[j] !== exp_y || colv[j] !== (exp_y != 8'h00)) begin
        errors++;
        $display("FAIL burst_stream j=%0d: y=%h y_valid=%b, required %h %b",
                 j, col[j], colv[j], exp_y, (exp_y != 8'h00));
      end
    end
    for (int c = 0; c < 20 && busy; c++) tick();
    checks++;
    if (busy !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL burst_drain: busy=%b level=%0d, required 0 0", busy, level);
    end
  endtask

  task automatic test_en_gate();
    en = 1'b0;
    push_code(3'd2);
    push_code(3'd4);
    push_code(3'd6);
    repeat (3) begin
      tick();
      checks++;
      if (y !== 8'h00 || level !== 3'd3) begin
        errors++;
        $display("FAIL en_hold: y=%h level=%0d, required 00 3", y, level);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (y !== 8'h04 || y_valid !== 1'b1 || level !== 3'd2) begin
      errors++;
      $display("FAIL en_start: y=%h y_valid=%b level=%0d, required 04 1 2", y, y_valid, level);
    end
    tick();
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (y !== 8'h04 || y_valid !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_finish: y=%h y_valid=%b, required 04 1", y, y_valid);
    end
    tick();
    checks++;
    if (y !== 8'h00 || y_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_gap: y=%h y_valid=%b, required 00 0", y, y_valid);
    end
    repeat (4) begin
      tick();
      checks++;
      if (y !== 8'h00 || y_valid !== 1'b0 || level !== 3'd2 || busy !== 1'b1) begin
        errors++;
        $display("FAIL en_drop_wait: y=%h y_valid=%b level=%0d busy=%b, required 00 0 2 1",
                 y, y_valid, level, busy);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    en = 1'b0;
    push_code(3'd3);
    push_code(3'd5);
    push_code(3'd7);
    en = 1'b1;
    tick();
    checks++;
    if (y !== 8'h08 || level !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_start: y=%h level=%0d, required 08 2", y, level);
    end
    tick();
    rst = 1'b1;
    code_in    = 3'd6;
    code_valid = 1'b1;
    tick();
    rst        = 1'b0;
    code_valid = 1'b0;
    checks++;
    if (y !== 8'h00 || y_valid !== 1'b0 || level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: y=%h y_valid=%b level=%0d busy=%b, required 00 0 0 0",
               y, y_valid, level, busy);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (y !== 8'h00 || level !== 3'd0) begin
        errors++;
        $display("FAIL rstmid_stale c=%0d: y=%h level=%0d, required 00 0", c, y, level);
      end
    end
  endtask

  task automatic test_full_pop();
    logic seen7 = 1'b0;
    en = 1'b0;
    push_code(3'd0);
    push_code(3'd1);
    push_code(3'd2);
    push_code(3'd3);
    checks++;
    if (level !== 3'd4 || code_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_flags: level=%0d code_ready=%b, required 4 0", level, code_ready);
    end
    en         = 1'b1;
    code_in    = 3'd7;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    checks++;
    if (level !== 3'd3 || y !== 8'h01) begin
      errors++;
      $display("FAIL full_pop: level=%0d y=%h, required 3 01", level, y);
    end
    for (int c = 0; c < 40 && busy; c++) begin
      tick();
      if (y == 8'h80) seen7 = 1'b1;
    end
    checks++;
    if (seen7 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_refused: refused code seen=%b busy=%b, required 0 0", seen7, busy);
    end
  endtask

  task automatic test_hold1();
    logic [7:0] col [16];
    int         idx = 0;
    int         ncol = 0;
    logic       hs;
    logic [7:0] exp_y;
    en1         = 1'b1;
    code_in1    = 3'd0;
    code_valid1 = 1'b1;
    for (int cyc = 0; cyc < 100 && ncol < 16; cyc++) begin
      hs = code_valid1 && code_ready1;
      tick();
      if (hs) idx++;
      code_valid1 = (idx < 8);
      code_in1    = 3'(idx);
      checks++;
      if (!$onehot0(y1)) begin
        errors++;
        $display("FAIL hold1_onehot cyc=%0d: y=%h, required zero or one-hot", cyc, y1);
      end
      if (ncol > 0 || y1 != 8'h00) begin
        col[ncol] = y1;
        ncol++;
      end
    end
    code_valid1 = 1'b0;
    checks++;
    if (ncol !== 16) begin
      errors++;
      $display("FAIL hold1_count: samples=%0d, required 16", ncol);
    end
    for (int j = 0; j < ncol; j++) begin
      exp_y = ((j % 2) == 0) ? (8'h01 << (j / 2)) : 8'h00;
      checks++;
      if (col[j] !== exp_y) begin
        errors++;
        $display("FAIL hold1_stream j=%0d: y=%h, required %h", j, col[j], exp_y);
      end
    end
    en1 = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    code_in     = 3'd0;
    code_valid  = 1'b0;
    en          = 1'b0;
    code_in1    = 3'd0;
    code_valid1 = 1'b0;
    en1         = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_en_gate();
    test_reset_mid_drive();
    test_full_pop();
    test_hold1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
